// File: rtl/host_ft245_cmd_sched.sv
// Round-robin command scheduler sharing the FT245 host model command interface between two requesters.
// Optional SEND timeout abort is enabled by defining HOST_FT245_CMD_SCHED_TIMEOUT_EN.
module host_ft245_cmd_sched #(
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned STATUS_SAMPLE  = 8,
  parameter int unsigned STATUS_SPAN    = 18,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [1:0] OP0,
  input  logic [1:0] OP1,
  input  logic [7:0] WDATA0,
  input  logic [7:0] WDATA1,
  output logic       GNT0,
  output logic       GNT1,
  output logic       DONE0,
  output logic       DONE1,
  output logic [7:0] RDATA,
  output logic       ERR,
  output logic       BUSY,
  output logic       READ_FT_245,
  output logic       WRITE_FT_245,
  output logic       READ_FT_STATUS,
  output logic [7:0] DATA_IN,
  input  logic [7:0] DATA_OUT,
  input  logic       HOST_FT245_RXF_N
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  localparam logic [1:0]  OP_ILLEGAL = 2'b00;
  localparam logic [1:0]  OP_SEND    = 2'b01;
  localparam logic [1:0]  OP_FETCH   = 2'b10;
  localparam logic [1:0]  OP_STATUS  = 2'b11;
  localparam logic [15:0] HOLD_C     = 16'(HOLD_CYCLES);
  localparam logic [15:0] GAP_C      = 16'(GAP_CYCLES);
  localparam logic [15:0] SAMPLE_C   = 16'(STATUS_SAMPLE);
  localparam logic [15:0] SPAN_END_C = 16'(STATUS_SPAN - 1);
  localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT_CYCLES);

  state_t      state_r;
  logic        port_r;
  logic        last_r;
  logic [1:0]  op_r;
  logic [7:0]  cap_r;
  logic [15:0] cnt_r;
  logic        rxf_r;
  logic        seen_low_r;

  logic        pick_s;
  logic [1:0]  op_s;
  logic [7:0]  wdata_s;
  logic [15:0] cnt_inc_s;
  logic [7:0]  cap_s;
  logic        finish_s;
  logic        fin_err_s;
  logic [7:0]  fin_rdata_s;

`ifndef HOST_FT245_CMD_SCHED_TIMEOUT_EN
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT_C;
`endif

  // Arbitration choice and saturating counter increment.
  always_comb begin
    pick_s = 1'b0;
    if (REQ0 && REQ1) begin
      pick_s = ~last_r;
    end else begin
      pick_s = REQ1;
    end
    op_s      = pick_s ? OP1 : OP0;
    wdata_s   = pick_s ? WDATA1 : WDATA0;
    cnt_inc_s = (cnt_r == 16'hFFFF) ? cnt_r : cnt_r + 16'd1;
  end

  // Completion decision for the command in flight; cnt_r is the offset from ISSUE.
  always_comb begin
    finish_s    = 1'b0;
    fin_err_s   = 1'b0;
    fin_rdata_s = RDATA;
    cap_s       = (cnt_r == SAMPLE_C) ? DATA_OUT : cap_r;
    case (state_r)
      ST_ISSUE: begin
        if (op_r == OP_ILLEGAL) begin
          finish_s  = 1'b1;
          fin_err_s = 1'b1;
        end else begin
          finish_s = 1'b0;
        end
      end
      ST_WAIT: begin
        case (op_r)
          OP_SEND: begin
            if (rxf_r && seen_low_r) begin
              finish_s = 1'b1;
`ifdef HOST_FT245_CMD_SCHED_TIMEOUT_EN
            end else if (cnt_r >= TIMEOUT_C) begin
              finish_s  = 1'b1;
              fin_err_s = 1'b1;
`endif
            end else begin
              finish_s = 1'b0;
            end
          end
          OP_FETCH: begin
            if (cnt_r >= HOLD_C) begin
              finish_s    = 1'b1;
              fin_rdata_s = DATA_OUT;
            end else begin
              finish_s = 1'b0;
            end
          end
          OP_STATUS: begin
            if (cnt_r >= SPAN_END_C) begin
              finish_s    = 1'b1;
              fin_rdata_s = cap_s;
            end else begin
              finish_s = 1'b0;
            end
          end
          default: begin
            finish_s  = 1'b1;
            fin_err_s = 1'b1;
          end
        endcase
      end
      default: finish_s = 1'b0;
    endcase
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r        <= ST_IDLE;
      port_r         <= 1'b0;
      last_r         <= 1'b1;
      op_r           <= 2'b00;
      cap_r          <= 8'h00;
      cnt_r          <= 16'd0;
      rxf_r          <= 1'b1;
      seen_low_r     <= 1'b0;
      GNT0           <= 1'b0;
      GNT1           <= 1'b0;
      DONE0          <= 1'b0;
      DONE1          <= 1'b0;
      RDATA          <= 8'h00;
      ERR            <= 1'b0;
      BUSY           <= 1'b0;
      READ_FT_245    <= 1'b0;
      WRITE_FT_245   <= 1'b0;
      READ_FT_STATUS <= 1'b0;
      DATA_IN        <= 8'h00;
    end else begin
      rxf_r <= HOST_FT245_RXF_N;
      case (state_r)
        ST_IDLE: begin
          if (REQ0 || REQ1) begin
            state_r    <= ST_ISSUE;
            BUSY       <= 1'b1;
            port_r     <= pick_s;
            last_r     <= pick_s;
            op_r       <= op_s;
            GNT0       <= ~pick_s;
            GNT1       <= pick_s;
            cnt_r      <= 16'd0;
            seen_low_r <= 1'b0;
            case (op_s)
              OP_SEND: begin
                READ_FT_245 <= 1'b1;
                DATA_IN     <= wdata_s;
              end
              OP_FETCH:  WRITE_FT_245   <= 1'b1;
              OP_STATUS: READ_FT_STATUS <= 1'b1;
              default:   DATA_IN        <= 8'h00;
            endcase
          end
        end
        ST_ISSUE, ST_WAIT: begin
          cnt_r          <= cnt_inc_s;
          READ_FT_STATUS <= 1'b0;
          if (!rxf_r) seen_low_r <= 1'b1;
          if (state_r == ST_WAIT && op_r == OP_STATUS) cap_r <= cap_s;
          if (finish_s) begin
            state_r      <= ST_RELEASE;
            READ_FT_245  <= 1'b0;
            WRITE_FT_245 <= 1'b0;
            DATA_IN      <= 8'h00;
            DONE0        <= ~port_r;
            DONE1        <= port_r;
            ERR          <= fin_err_s;
            RDATA        <= fin_rdata_s;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_RELEASE: begin
          DONE0   <= 1'b0;
          DONE1   <= 1'b0;
          GNT0    <= 1'b0;
          GNT1    <= 1'b0;
          cnt_r   <= 16'd1;
          state_r <= ST_GAP;
        end
        ST_GAP: begin
          if (cnt_r >= GAP_C) begin
            state_r <= ST_IDLE;
            BUSY    <= 1'b0;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          GNT0           <= 1'b0;
          GNT1           <= 1'b0;
          DONE0          <= 1'b0;
          DONE1          <= 1'b0;
          BUSY           <= 1'b0;
          READ_FT_245    <= 1'b0;
          WRITE_FT_245   <= 1'b0;
          READ_FT_STATUS <= 1'b0;
          DATA_IN        <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_ft245_cmd_sched.sv
// Self-checking bench for host_ft245_cmd_sched: vector table plus scoreboard of expected completions,
// with a small device model for RXF_N handshakes and status byte sequencing.
module tb_host_ft245_cmd_sched;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       REQ0 = 1'b0, REQ1 = 1'b0;
  logic [1:0] OP0 = 2'b00, OP1 = 2'b00;
  logic [7:0] WDATA0 = 8'h00, WDATA1 = 8'h00;
  logic       GNT0, GNT1, DONE0, DONE1, ERR, BUSY;
  logic       READ_FT_245, WRITE_FT_245, READ_FT_STATUS;
  logic [7:0] RDATA, DATA_IN;
  logic [7:0] DATA_OUT = 8'h00;
  logic       HOST_FT245_RXF_N = 1'b1;

  always #5 CLK = ~CLK;

  host_ft245_cmd_sched #(.TIMEOUT_CYCLES(32)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0(REQ0), .REQ1(REQ1), .OP0(OP0), .OP1(OP1),
    .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .RDATA(RDATA), .ERR(ERR), .BUSY(BUSY),
    .READ_FT_245(READ_FT_245), .WRITE_FT_245(WRITE_FT_245), .READ_FT_STATUS(READ_FT_STATUS),
    .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .HOST_FT245_RXF_N(HOST_FT245_RXF_N)
  );

  typedef struct {
    logic       port;
    logic       err;
    logic [7:0] rdata;
    logic       chk;
    int         lat;
    int         lvl;
    logic [7:0] wdata;
  } exp_t;

  typedef struct {
    logic       port;
    logic [1:0] op;
    logic [7:0] wdata;
    logic [7:0] fifo;
    logic       err;
    logic [7:0] rdata;
    logic       chk;
    int         lat;
    int         lvl;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic port, input logic err, input logic [7:0] rdata,
                          input logic chk, input int lat, input int lvl, input logic [7:0] wdata);
    exp_t x;
    x.port = port; x.err = err; x.rdata = rdata; x.chk = chk;
    x.lat = lat; x.lvl = lvl; x.wdata = wdata;
    sb.push_back(x);
  endtask

  // Device model: FIFO byte on DATA_OUT, status bytes 0x40+offset after READ_FT_STATUS,
  // and an RXF_N low pulse while READ_FT_245 is held (unless muted).
  logic [7:0] fifo_byte = 8'h00;
  logic       dev_mute = 1'b0;
  int         soff = 99;
  int         rd_k = 0;
  always @(negedge CLK) begin
    if (READ_FT_STATUS) soff = 0;
    else if (soff < 99) soff = soff + 1;
    DATA_OUT = (soff < 20) ? (8'h40 + 8'(soff)) : fifo_byte;
    if (READ_FT_245) begin
      rd_k = rd_k + 1;
      if (!dev_mute && rd_k == 3) HOST_FT245_RXF_N = 1'b0;
      else if (rd_k == 5) HOST_FT245_RXF_N = 1'b1;
    end else begin
      rd_k = 0;
      HOST_FT245_RXF_N = 1'b1;
    end
  end

  // Protocol monitor: timing from grant, level exclusivity/spacing, and scoreboard pop on DONE.
  int   cyc = 0, gnt_cyc = 0, lvl_cnt = 0, low_run = 0;
  logic gnt_q = 1'b0, lvl_q = 1'b0, had_lvl = 1'b0;
  logic excl_bad = 1'b0, space_bad = 1'b0, din_bad = 1'b0;
  logic lvl;
  always @(negedge CLK) begin
    cyc++;
    lvl = READ_FT_245 | WRITE_FT_245 | READ_FT_STATUS;
    if ($countones({READ_FT_245, WRITE_FT_245, READ_FT_STATUS}) > 1) excl_bad = 1'b1;
    if ((GNT0 | GNT1) && !gnt_q) begin
      gnt_cyc = cyc;
      lvl_cnt = 0;
    end
    if (lvl) begin
      if (!lvl_q && had_lvl && low_run < 3) space_bad = 1'b1;
      lvl_cnt++;
      low_run = 0;
      had_lvl = 1'b1;
    end else begin
      low_run++;
    end
    if (READ_FT_245 && sb.size() > 0 && DATA_IN !== sb[0].wdata) din_bad = 1'b1;
    if (DONE0 || DONE1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {DONE1, DONE0}, 2'b00);
      end else begin
        e = sb.pop_front();
        check("done_port", {DONE1, DONE0}, e.port ? 2'b10 : 2'b01);
        check("gnt_at_done", {GNT1, GNT0}, e.port ? 2'b10 : 2'b01);
        check("err", ERR, e.err);
        if (e.chk) check("rdata", RDATA, e.rdata);
        check("done_latency", cyc - gnt_cyc, e.lat);
        check("level_cycles", lvl_cnt, e.lvl);
        check("data_in_stable", din_bad, 1'b0);
        din_bad = 1'b0;
      end
    end
    gnt_q = GNT0 | GNT1;
    lvl_q = lvl;
  end

  int   n_done;
  logic got;

  initial begin
    vecs[0] = '{1'b0, 2'b10, 8'h00, 8'hA5, 1'b0, 8'hA5, 1'b1,  5,  5};
    vecs[1] = '{1'b1, 2'b01, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b0,  6,  6};
    vecs[2] = '{1'b0, 2'b11, 8'h00, 8'h00, 1'b0, 8'h48, 1'b1, 18,  1};
    vecs[3] = '{1'b1, 2'b10, 8'h00, 8'h5A, 1'b0, 8'h5A, 1'b1,  5,  5};
    vecs[4] = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0,  1,  0};
    vecs[5] = '{1'b1, 2'b11, 8'h00, 8'h00, 1'b0, 8'h48, 1'b1, 18,  1};
    vecs[6] = '{1'b0, 2'b01, 8'hC3, 8'h00, 1'b0, 8'h00, 1'b0,  6,  6};
    vecs[7] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0,  1,  0};

    repeat (3) @(negedge CLK);
    check("reset_outputs", {GNT0, GNT1, DONE0, DONE1, ERR, BUSY, READ_FT_245, WRITE_FT_245,
                            READ_FT_STATUS, RDATA, DATA_IN}, 32'd0);
    RST_N = 1'b1;

    // Contention from reset: both ports request FETCH continuously, grants alternate from port 0.
    fifo_byte = 8'h11;
    OP0 = 2'b10; OP1 = 2'b10;
    for (int k = 0; k < 4; k++) push_exp(k[0], 1'b0, 8'h11, 1'b1, 5, 5, 8'h00);
    REQ0 = 1'b1; REQ1 = 1'b1;
    n_done = 0;
    for (int t = 0; t < 200 && n_done < 4; t++) begin
      @(negedge CLK);
      if (DONE0 || DONE1) n_done++;
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    check("contention_done_count", n_done, 4);
    repeat (4) @(negedge CLK);

    // Vector table: one command at a time.
    for (int i = 0; i < 8; i++) begin
      fifo_byte = vecs[i].fifo;
      push_exp(vecs[i].port, vecs[i].err, vecs[i].rdata, vecs[i].chk, vecs[i].lat, vecs[i].lvl, vecs[i].wdata);
      if (vecs[i].port) begin
        OP1 = vecs[i].op; WDATA1 = vecs[i].wdata; REQ1 = 1'b1;
      end else begin
        OP0 = vecs[i].op; WDATA0 = vecs[i].wdata; REQ0 = 1'b1;
      end
      got = 1'b0;
      for (int t = 0; t < 100; t++) begin
        @(negedge CLK);
        if (vecs[i].port ? DONE1 : DONE0) begin
          got = 1'b1;
          break;
        end
      end
      REQ0 = 1'b0; REQ1 = 1'b0;
      check("vec_done_seen", got, 1'b1);
      check("busy_at_done", BUSY, 1'b1);
      repeat (4) @(negedge CLK);
      check("idle_after_gap", {BUSY, GNT0, GNT1}, 3'b000);
    end

`ifdef HOST_FT245_CMD_SCHED_TIMEOUT_EN
    // SEND with no device read aborts after the timeout.
    dev_mute = 1'b1;
    push_exp(1'b0, 1'b1, 8'h00, 1'b0, 33, 33, 8'h99);
    OP0 = 2'b01; WDATA0 = 8'h99; REQ0 = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge CLK);
      if (DONE0) begin
        got = 1'b1;
        break;
      end
    end
    REQ0 = 1'b0;
    dev_mute = 1'b0;
    check("timeout_done_seen", got, 1'b1);
    repeat (4) @(negedge CLK);
`endif

    // Reset in the middle of a port-0 FETCH; afterwards port 0 must still win a tie.
    fifo_byte = 8'h77;
    OP0 = 2'b10; REQ0 = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge CLK);
      if (WRITE_FT_245) begin
        got = 1'b1;
        break;
      end
    end
    check("fetch_started_before_reset", got, 1'b1);
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1 check("async_reset_outputs", {GNT0, GNT1, DONE0, DONE1, ERR, BUSY, READ_FT_245, WRITE_FT_245,
                                     READ_FT_STATUS, RDATA, DATA_IN}, 32'd0);
    REQ0 = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    OP0 = 2'b10; OP1 = 2'b10;
    push_exp(1'b0, 1'b0, 8'h77, 1'b1, 5, 5, 8'h00);
    push_exp(1'b1, 1'b0, 8'h77, 1'b1, 5, 5, 8'h00);
    REQ0 = 1'b1; REQ1 = 1'b1;
    n_done = 0;
    for (int t = 0; t < 100 && n_done < 2; t++) begin
      @(negedge CLK);
      if (DONE0) REQ0 = 1'b0;
      if (DONE1) REQ1 = 1'b0;
      if (DONE0 || DONE1) n_done++;
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    check("post_reset_done_count", n_done, 2);

    repeat (5) @(negedge CLK);
    check("scoreboard_drained", sb.size(), 0);
    check("level_exclusive", excl_bad, 1'b0);
    check("level_spacing", space_bad, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
